logic_accum_unit: RTL
=====================

# logic_accum_unit

Parametrised, handshaked successor to the team's registered AND/OR test block. It computes one of eight bitwise operations on two WIDTH-bit operands. It either returns each result individually or folds a burst of beats into a running accumulator and returns one result per burst. It sits as a utility datapath stage behind the bus fabric, with valid/ready flow control on both sides.

## Interface
- WIDTH, 32, operand/result width in bits (≥1)
- CNT_W, 8, width of burst beat counter (≥2)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  unit can accept a beat this cycle
- in_op  input  3  operation code (see Operation)
- in_acc  input  1  beat opens an accumulate burst (sampled in IDLE only)
- in_last  input  1  beat closes the current burst
- in_c  input  WIDTH  operand C
- in_d  input  WIDTH  operand D
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_y  output  WIDTH  result
- out_zero  output  1  out_y == 0
- out_count  output  CNT_W  beats folded into out_y, saturating at 2^CNT_W−1
- busy  output  1  accumulate burst open (state ACCUM)

## Operation
- Opcodes use f(x,d): 0 AND x&d, 1 OR x|d, 2 XOR x^d, 3 NAND ~(x&d), 4 NOR ~(x|d), 5 XNOR ~(x^d), 6 ANDN x&~d, 7 PASS d.
- Accept: a beat is accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready. It is combinational and has no dependency on in_valid.
- FSM states are IDLE and ACCUM. busy = (state == ACCUM).
- IDLE, accepted beat with in_acc=0 or in_last=1: result f(in_c,in_d) is loaded to the output register with count 1. State stays IDLE.
- IDLE, accepted beat with in_acc=1 and in_last=0: acc ← f(in_c,in_d) and cnt ← 1. Go to ACCUM. No output is produced.
- ACCUM, accepted beat with in_last=0: acc ← f(acc,in_d) and cnt ← sat(cnt+1). in_c and in_acc are ignored. No output is produced.
- ACCUM, accepted beat with in_last=1: output ← f(acc,in_d) and count ← sat(cnt+1). Go to IDLE.
- The opcode is taken per beat, so a burst may mix operations.
- Output register: out_y, out_zero and out_count are loaded together and out_valid is set.
- out_valid clears on out_ready when no new result is loaded in the same cycle.
- A simultaneous drain and load keeps out_valid=1 and shows the new result.
- out_y, out_zero and out_count are held stable while out_valid && !out_ready.
- Non-last ACCUM beats are accepted under the same in_ready rule as other beats; this is deliberately conservative.
- Counter saturation: cnt stops at 2^CNT_W−1. It never wraps.
- Reset (async assert, any state, including mid-burst): out_valid=0, out_y=0, out_zero=0, out_count=0, busy=0, acc=0, cnt=0, state=IDLE.
- After reset an open burst is discarded and no partial result is emitted.
- Reset deassertion is synchronised externally, so the first accept can occur on the first rising edge after rst_n rises.

## Timing
- Latency: result visible on out_y/out_valid one cycle after the accepting edge of the closing (or single) beat.
- Throughput: one beat per cycle while out_ready=1. One result per cycle for non-accumulate traffic.
- Backpressure: with out_valid=1 and out_ready=0, in_ready=0. No beats are accepted and the accumulator is frozen.
- All state changes occur on the rising clk edge, except reset.

## Test plan
- Reset mid-burst: open burst with 3 beats, assert rst_n=0 asynchronously → outputs immediately zero and busy=0; after release, a single beat AND C=0xF0F0F0F0 D=0xFF00FF00 → out_y=0xF000F000, count=1.
- All opcodes, single beats: C=0x0000FFFF, D=0x00FF00FF → AND 0x000000FF, OR 0x00FFFFFF, XOR 0x00FFFF00, NAND 0xFFFFFF00, NOR 0xFF000000, XNOR 0xFF0000FF, ANDN 0x0000FF00, PASS 0x00FF00FF. Each appears one cycle after accept with out_zero=0.
- Accumulate burst:
  - Beat 1: OR, acc=1, C=0x1, D=0x2.
  - Beat 2: OR, D=0x4.
  - Beat 3: XOR, last=1, D=0x7.
  - Expected: out_y=0, out_zero=1, count=3, busy high between beats 1 and 3; no output before beat 3.
- Backpressure: two back-to-back single beats with out_ready=0 for 4 cycles → in_ready=0 after first result, out_y stable, second beat accepted in the drain cycle and shown next cycle.
- Saturation with CNT_W=2: burst of 6 beats → out_count=3.
- Single-beat burst: in_acc=1, in_last=1, NOR C=0 D=0 → out_y=all ones, count=1, busy never asserted.

Source files
------------

// File: rtl/logic_accum_unit.sv
// Bitwise logic unit with valid/ready handshake on both sides. It returns single-beat
// results, or it folds a burst into an accumulator and returns one result per burst.
module logic_accum_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    input  logic             in_last,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_y;
    logic             r_zero;
    logic [CNT_W-1:0] r_count;
    logic             r_valid;

    logic             w_accept;
    logic             w_is_accum;
    logic             w_load;
    logic             w_fold;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_res;
    logic [CNT_W-1:0] w_cnt_nxt;

    function automatic logic [WIDTH-1:0] f_op(input logic [2:0] op,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] d);
        case (op)
            3'd0:    return x & d;
            3'd1:    return x | d;
            3'd2:    return x ^ d;
            3'd3:    return ~(x & d);
            3'd4:    return ~(x | d);
            3'd5:    return ~(x ^ d);
            3'd6:    return x & ~d;
            default: return d;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] c);
        if (&c) return c;
        return c + 1'b1;
    endfunction

    assign w_accept   = in_valid && in_ready;
    assign w_is_accum = (r_state == S_ACCUM);
    // Inside a burst the accumulator replaces operand C.
    assign w_x        = w_is_accum ? r_acc : in_c;
    assign w_res      = f_op(in_op, w_x, in_d);
    assign w_cnt_nxt  = w_is_accum ? f_sat_inc(r_cnt) : CNT_W'(1);
    assign w_load     = w_accept && (in_last || (!w_is_accum && !in_acc));
    assign w_fold     = w_accept && !w_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && in_acc && !in_last) w_state_nxt = S_ACCUM;
            S_ACCUM: if (w_accept && in_last)            w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state == S_ACCUM);
        in_ready  = !r_valid || out_ready;
        out_valid = r_valid;
        out_y     = r_y;
        out_zero  = r_zero;
        out_count = r_count;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_y     <= '0;
            r_zero  <= 1'b0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_fold) begin
                r_acc <= w_res;
                r_cnt <= w_cnt_nxt;
            end
            if (w_load) begin
                r_y     <= w_res;
                r_zero  <= (w_res == '0);
                r_count <= w_cnt_nxt;
                r_valid <= 1'b1;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule
